// File: rtl/aes128_decrypt_iter_pkg.sv
// aes_pkg: shared AES definitions for the decryptor (and the encryptor beside it).
//   - byte/word/block typedefs, decryptor FSM state enum
//   - rcon(): round constants Rcon[1..10]
//   - GF(2^8) helpers over 0x11b: xtime, gf_mul, gf_inv, mul09/0b/0d/0e
//   - sbox()/inv_sbox(): computed from the field inverse plus the affine map,
//     so there is no hand-entered table to get wrong
//   - inv_mix_col(): InvMixColumns on one 32-bit column
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_DEC} state_e;

  function automatic byte_t rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic byte_t xtime(input byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); 0 maps to 0 as AES requires.
  function automatic byte_t gf_inv(input byte_t x);
    byte_t r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);  // x^3,7,..,127
    return gf_mul(r, r);
  endfunction

  function automatic byte_t mul09(input byte_t x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction
  function automatic byte_t mul0b(input byte_t x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction
  function automatic byte_t mul0d(input byte_t x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction
  function automatic byte_t mul0e(input byte_t x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  function automatic byte_t sbox(input byte_t x);
    byte_t b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic byte_t inv_sbox(input byte_t y);
    return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
  endfunction

  function automatic word_t inv_mix_col(input word_t c);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
            mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
            mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
            mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
  endfunction

endpackage

// File: rtl/aes128_decrypt_iter_if.sv
// aes128_decrypt_iter_if: request/response bundle of the AES-128 decryptor.
//   start    : request pulse (master -> slave)
//   data_in  : ciphertext, byte 0 in [127:120]
//   key_in   : cipher key (round-0 key)
//   data_out : plaintext, held until the next done
//   done     : one-cycle completion pulse
//   busy     : operation in progress
interface aes128_decrypt_iter_if;
  logic         start;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] data_out;
  logic         done;
  logic         busy;

  modport master (output start, data_in, key_in, input data_out, done, busy);
  modport slave  (input start, data_in, key_in, output data_out, done, busy);
endinterface

// File: rtl/aes128_decrypt_iter_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
//   i_state : current state block
//   i_key   : round key for AddRoundKey
//   i_last  : 1 = final round (InvMixColumns bypassed)
//   o_state : InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(s)), k)),
//             or without InvMixColumns when i_last
// Byte i of a block sits in bits [127-8i -: 8]; byte (row r, column c) is i=4c+r.
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t i_state,
  input  block_t i_key,
  input  logic   i_last,
  output block_t o_state
);

  block_t w_shr, w_sub, w_ark, w_imc;

  // 16 inverse S-boxes, each fed from its InvShiftRows source byte:
  // out[r][c] = in[r][(c - r) mod 4].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4*c + r;
      localparam int SRC = 4*((c - r + 4) % 4) + r;
      assign w_shr[127-8*DST -: 8] = i_state[127-8*SRC -: 8];
      assign w_sub[127-8*DST -: 8] = inv_sbox(w_shr[127-8*DST -: 8]);
    end
    assign w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
  end

  assign w_ark   = w_sub ^ i_key;
  assign o_state = i_last ? w_ark : w_imc;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 decryptor, one inverse round per clock.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset (aborts any operation)
//   io_bus : aes128_decrypt_iter_if.slave (start/data_in/key_in in,
//            data_out/done/busy out)
// Flow: IDLE -> KEXP (10 forward key steps to k10) -> DEC (11 cycles, key
// schedule run backwards k10..k0 alongside the inverse rounds) -> IDLE.
// Optional build macro AES_DEC_KEY_CACHE_EN: remembers the last key and its
// k10 so a repeated key skips KEXP (11-cycle latency instead of 21).
module aes128_decrypt_iter
  import aes_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  aes128_decrypt_iter_if.slave         io_bus
);

  state_e     r_fsm, w_fsm_nxt;
  block_t     r_state, r_key, r_dout;
  logic [3:0] r_rnd;
  logic       r_done;

  logic       w_last, w_accept, w_hit;
  byte_t      w_rc;
  word_t      w_sub_in, w_rot, w_sub_out;
  word_t      w_k0, w_k1, w_k2, w_k3;
  word_t      w_f0, w_f1, w_f2, w_f3;
  word_t      w_r0, w_r1, w_r2, w_r3;
  block_t     w_key_fwd, w_key_rev, w_round;

  // The completing DEC edge doubles as the IDLE sampling point, so a start
  // held through done chains the next block without a bubble.
  assign w_last   = (r_fsm == S_DEC) && (r_rnd == 4'd0);
  assign w_accept = io_bus.start && ((r_fsm == S_IDLE) || w_last);

`ifdef AES_DEC_KEY_CACHE_EN
  block_t r_ckey, r_ck10;
  logic   r_cvld;
  assign w_hit = r_cvld && (io_bus.key_in == r_ckey);
`else
  assign w_hit = 1'b0;
`endif

  // ---------------- key step (shared 4 forward S-boxes) ----------------
  assign {w_k0, w_k1, w_k2, w_k3} = r_key;

  // Forward step substitutes w3; reverse step substitutes the recovered
  // w3' = w3 ^ w2 of the previous key.
  assign w_sub_in = (r_fsm == S_DEC) ? (w_k3 ^ w_k2) : w_k3;
  assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};
  assign w_rc     = (r_fsm == S_DEC) ? rcon(r_rnd) : rcon(r_rnd + 4'd1);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign w_sub_out[8*g +: 8] = sbox(w_rot[8*g +: 8]);
  end

  assign w_f0 = w_k0 ^ w_sub_out ^ {w_rc, 24'h0};
  assign w_f1 = w_k1 ^ w_f0;
  assign w_f2 = w_k2 ^ w_f1;
  assign w_f3 = w_k3 ^ w_f2;
  assign w_key_fwd = {w_f0, w_f1, w_f2, w_f3};

  assign w_r3 = w_k3 ^ w_k2;
  assign w_r2 = w_k2 ^ w_k1;
  assign w_r1 = w_k1 ^ w_k0;
  assign w_r0 = w_k0 ^ w_sub_out ^ {w_rc, 24'h0};
  assign w_key_rev = {w_r0, w_r1, w_r2, w_r3};

  // ---------------- inverse round datapath ----------------
  aes_inv_round u_round (
    .i_state (r_state),
    .i_key   (r_key),
    .i_last  (r_rnd == 4'd0),
    .o_state (w_round)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: if (w_accept) w_fsm_nxt = w_hit ? S_DEC : S_KEXP;
      S_KEXP: if (r_rnd == 4'd9) w_fsm_nxt = S_DEC;
      S_DEC:  if (w_last) begin
                if (w_accept) w_fsm_nxt = w_hit ? S_DEC : S_KEXP;
                else          w_fsm_nxt = S_IDLE;
              end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  // In DEC, r_rnd counts 10 (initial AddRoundKey) down to 0 (final round);
  // r_key always holds k_r for the round being executed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= '0;
      r_key   <= '0;
      r_dout  <= '0;
      r_rnd   <= '0;
      r_done  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      r_ckey  <= '0;
      r_ck10  <= '0;
      r_cvld  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        S_KEXP: begin
          r_key <= w_key_fwd;
          if (r_rnd == 4'd9) begin
            r_rnd <= 4'd10;
`ifdef AES_DEC_KEY_CACHE_EN
            r_ck10 <= w_key_fwd;
            r_cvld <= 1'b1;
`endif
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        S_DEC: begin
          if (r_rnd == 4'd10) begin
            r_state <= r_state ^ r_key;
            r_key   <= w_key_rev;
            r_rnd   <= 4'd9;
          end else if (r_rnd != 4'd0) begin
            r_state <= w_round;
            r_key   <= w_key_rev;
            r_rnd   <= r_rnd - 4'd1;
          end else begin
            r_state <= w_round;
            r_dout  <= w_round;
            r_done  <= 1'b1;
          end
        end
        default: ;
      endcase
      // Acceptance overrides the round update of the completing cycle.
      if (w_accept) begin
        r_state <= io_bus.data_in;
        if (w_hit) begin
`ifdef AES_DEC_KEY_CACHE_EN
          r_key <= r_ck10;
`endif
          r_rnd <= 4'd10;
        end else begin
          r_key <= io_bus.key_in;
          r_rnd <= 4'd0;
`ifdef AES_DEC_KEY_CACHE_EN
          r_ckey <= io_bus.key_in;
          r_cvld <= 1'b0;
`endif
        end
      end
    end
  end

  assign io_bus.data_out = r_dout;
  assign io_bus.done     = r_done;
  assign io_bus.busy     = (r_fsm != S_IDLE);

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed bench for aes128_decrypt_iter: FIPS-197 C.1 and Appendix B
// vectors, back-to-back chaining, start while busy, reset abort, and the
// key-cache reuse path when AES_DEC_KEY_CACHE_EN is defined.
module tb_aes128_decrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  logic clk, reset;
  int   n_pass = 0;
  int   n_tot  = 0;

  aes128_decrypt_iter_if bus ();

  aes128_decrypt_iter dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated operation from IDLE: busy/done every cycle, result at lat.
  task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] key,
                        input logic [127:0] pt, input int lat);
    bus.data_in = ct;
    bus.key_in  = key;
    bus.start   = 1'b1;
    tick;
    bus.start   = 1'b0;
    chk({tag, ":busy_t0"}, bus.busy, 1);
    for (int k = 1; k <= lat; k++) begin
      tick;
      if (k < lat) begin
        chk({tag, ":busy"}, bus.busy, 1);
        chk({tag, ":done_early"}, bus.done, 0);
      end else begin
        chk({tag, ":done"}, bus.done, 1);
        chk({tag, ":busy_end"}, bus.busy, 0);
        chk({tag, ":data_out"}, bus.data_out, pt);
      end
    end
    tick;
    chk({tag, ":done_pulse"}, bus.done, 0);
    chk({tag, ":data_hold"}, bus.data_out, pt);
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.key_in  = '0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("rst:data_out", bus.data_out, 0);
    chk("rst:done", bus.done, 0);
    chk("rst:busy", bus.busy, 0);

    // C.1 with a stray start at T0+5, inputs scrambled after acceptance,
    // and start held through completion to chain the Appendix B block.
    bus.data_in = C1_CT;
    bus.key_in  = C1_KEY;
    bus.start   = 1'b1;
    tick;
    chk("c1:busy_t0", bus.busy, 1);
    bus.start   = 1'b0;
    bus.data_in = 128'hdeadbeef_00000000_cafef00d_12345678;
    bus.key_in  = 128'h0f0e0d0c0b0a09080706050403020100;
    for (int k = 1; k <= 21; k++) begin
      if (k == 5) bus.start = 1'b1;
      if (k == 6) bus.start = 1'b0;
      if (k == 21) begin
        bus.start   = 1'b1;
        bus.data_in = B_CT;
        bus.key_in  = B_KEY;
      end
      tick;
      if (k == 10) chk("c1:k10_probe", dut.r_key, C1_K10);
      if (k < 21) begin
        chk("c1:busy", bus.busy, 1);
        chk("c1:done_early", bus.done, 0);
      end else begin
        chk("c1:done", bus.done, 1);
        chk("c1:data_out", bus.data_out, C1_PT);
        chk("c1:busy_chained", bus.busy, 1);
      end
    end
    bus.start = 1'b0;

    // Chained Appendix B block, accepted at the C.1 completing edge.
    for (int k = 1; k <= 21; k++) begin
      tick;
      if (k == 10) chk("b:prev_hold", bus.data_out, C1_PT);
      if (k < 21) begin
        chk("b:busy", bus.busy, 1);
        chk("b:done_early", bus.done, 0);
      end else begin
        chk("b:done", bus.done, 1);
        chk("b:busy_end", bus.busy, 0);
        chk("b:data_out", bus.data_out, B_PT);
      end
    end
    tick;
    chk("b:done_pulse", bus.done, 0);
    chk("b:data_hold", bus.data_out, B_PT);

    // Reset abort at T0+15.
    bus.data_in = C1_CT;
    bus.key_in  = C1_KEY;
    bus.start   = 1'b1;
    tick;
    bus.start   = 1'b0;
    repeat (15) tick;
    chk("abort:busy_pre", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort:done", bus.done, 0);
    chk("abort:busy", bus.busy, 0);
    chk("abort:data_out", bus.data_out, 0);
    tick;
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick;
      chk("abort:no_done", bus.done, 0);
      chk("abort:idle", bus.busy, 0);
    end

    run_op("c1_fresh", C1_CT, C1_KEY, C1_PT, 21);
    run_op("c1_again", C1_CT, C1_KEY, C1_PT, HIT_LAT);
    run_op("b_miss", B_CT, B_KEY, B_PT, 21);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt_iter.md
# aes128_decrypt_iter

Iterative AES-128 decryption core, the inverse of the outer-round pipelined AES-128 encryptor: it accepts one ciphertext block plus the original cipher key and returns the plaintext. It executes one inverse round per clock. The last-round key is derived on chip by forward expansion, and earlier round keys are recovered by running the key schedule in reverse, so no round-key RAM is needed. It sits beside the encryptor in the crypto datapath and shares its S-box and round-constant definitions.

## Interface
- No parameters; the block is fixed at AES-128 (Nk=4, Nr=10).
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `data_in` input 128: ciphertext, FIPS-197 byte order (byte 0 in bits [127:120]).
- `key_in` input 128: cipher key (round-0 key), same byte order.
- `data_out` output 128: plaintext; holds its value until the next `done`.
- `done` output 1: one-cycle pulse; `data_out` is valid from this cycle.
- `busy` output 1: high while an operation is in progress.

## Operation
- States: IDLE, KEXP, DEC.
- **IDLE:** when `start`=1 at an edge, latch `data_in` into the state register and `key_in` into the key register, clear the round counter, and go to KEXP.
- **KEXP:** 10 cycles of forward expansion, key ← next(key, Rcon[r]) for r=1..10. After the 10th cycle the key register holds k10; go to DEC.
- **DEC cycle 0:** state ← state ^ k10; key ← k9 (reverse step).
- **DEC cycles 1..9** (r=9..1): state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), k_r)); key ← k_{r-1}.
- **DEC cycle 10:** state ← AddRoundKey(InvSubBytes(InvShiftRows(state)), k0). The result is loaded into `data_out`, `done` pulses, and the FSM returns to IDLE.
- **Reverse key step**, words w0..w3 of k_r:
  - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon[r].
  - Rcon[r] ∈ {01,02,04,08,10,20,40,80,1b,36} for r=1..10.
- **Arithmetic:** GF(2^8) uses polynomial 0x11b. InvMixColumns coefficients are 0e/0b/0d/09. All data is 128-bit; there is no truncation.
- **Boundary conditions:**
  - `start` while busy: ignored, with no effect on the running operation.
  - `start` in the `done` cycle: the FSM is already in IDLE, so the start is accepted and the next operation begins.
  - `data_in`/`key_in` changes after acceptance: no effect on the running operation.
  - `reset` asserted mid-operation: abort immediately and discard the partial result.

## Timing
- **Reset values:** `data_out`=0, `done`=0, `busy`=0, FSM=IDLE, all internal registers 0.
- **Acceptance:** `start` is accepted at edge T0. `busy`=1 from T0 through T0+20 and falls at the edge where `done` rises.
- **Latency without cache hit:** 10 (KEXP) + 11 (DEC) = 21 cycles. `done` is high for exactly one cycle after edge T0+21.
- **Throughput:** one block per 21 cycles.
- **Back-to-back:** with `start` held high, the next operation is accepted at T0+21 and completes at T0+42.

## Configuration
- **Macro:** `AES_DEC_KEY_CACHE_EN`.
- **Defined:**
  - Add a 128-bit cache holding the last cipher key and a 128-bit cache holding its k10, plus a valid bit that is cleared by `reset`.
  - On accepted `start` with a valid cache and `key_in` equal to the cached key, load k10 directly and go straight to DEC. Latency is 11 cycles and `busy` is high for T0..T0+10.
  - On a miss, behave as without the macro and refresh the cache at KEXP exit.
- **Undefined:** no cache registers; latency is always 21 cycles.

## Structure
- **Package `aes_pkg`:**
  - Rcon array.
  - GF helper functions: xtime, multiply by 09/0b/0d/0e.
  - Forward S-box function, also used by the encryptor.
  - State/word typedefs (byte, 32-bit word, 128-bit block).
  - FSM state enum.
- **Sub-module `aes_inv_round`:** combinational InvShiftRows + InvSubBytes + AddRoundKey + optional InvMixColumns, selected by a `last` input. It contains 16 inverse S-box instances.
- **Top level:** FSM, counter, key registers, and the reverse/forward key step using 4 forward S-boxes.

## Test plan
- **FIPS-197 C.1:** key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a → `data_out`=00112233445566778899aabbccddeeff. `done` occurs exactly 21 cycles after `start`; `busy` is checked at every cycle.
- **Key-schedule probe:** for the C.1 key, the internal key register equals 13111d7fe3944a17f307a78b4d2b30c5 at KEXP exit.
- **FIPS-197 Appendix B:** key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. The bench issues it back-to-back by holding `start` high through `done` after C.1.
- **Start while busy:** pulse `start` with different data at cycle T0+5 → ignored; the C.1 result is unchanged and no extra `done` occurs.
- **Reset abort:** assert `reset` at cycle T0+15 → `done`, `busy` and `data_out` are 0 immediately. A fresh C.1 run afterwards then completes correctly.
- **`AES_DEC_KEY_CACHE_EN` reuse:** with the macro defined, C.1 is run twice with the same key. The second run gives `done` after 11 cycles with a correct result. A third run with the B key is a miss and takes 21 cycles.
